// File: rtl/nop_meta_assembler.sv
`default_nettype none
// ============================================================================
// Module      : nop_meta_assembler
// Description : Assembles tagged NOP-lane metadata fragments into words of up
//               to 32 bits and buffers them in a 2-entry output FIFO.
//               Optional statistics counters: define NOP_META_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nop_meta_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        meta_valid,
    input  logic [9:0]  meta_in,
    input  logic        stall_decode,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_word,
    output logic [2:0]  out_len,
    output logic        seq_err,
    output logic        drop,
    output logic [15:0] words_done,
    output logic [7:0]  err_count
);
    localparam logic [1:0] c_TAG_CONT   = 2'b00;
    localparam logic [1:0] c_TAG_START  = 2'b01;
    localparam logic [1:0] c_TAG_END    = 2'b10;
    localparam logic [1:0] c_TAG_SINGLE = 2'b11;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_buf, w_buf_nxt;
    logic        w_take, w_push, w_err;
    logic [31:0] w_word, w_buf_ins, w_single;
    logic [2:0]  w_len;
    logic [1:0]  w_tag;

    assign w_take    = meta_valid && !stall_decode;
    assign w_tag     = meta_in[9:8];
    assign w_single  = {24'b0, meta_in[7:0]};
    // Unfilled lanes are always zero, so OR-ing the shifted byte stores it.
    assign w_buf_ins = r_buf | (w_single << {r_cnt[1:0], 3'b000});

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_buf_nxt   = r_buf;
        w_push      = 1'b0;
        w_word      = '0;
        w_len       = '0;
        w_err       = 1'b0;
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_buf_nxt   = '0;
        end else if (w_take) begin
            if (r_state == S_IDLE) begin
                case (w_tag)
                    c_TAG_START: begin
                        w_buf_nxt   = w_single;
                        w_cnt_nxt   = 3'd1;
                        w_state_nxt = S_COLLECT;
                    end
                    c_TAG_SINGLE: begin
                        w_push = 1'b1;
                        w_word = w_single;
                        w_len  = 3'd1;
                    end
                    default: w_err = 1'b1;
                endcase
            end else begin
                case (w_tag)
                    c_TAG_CONT, c_TAG_END: begin
                        if (r_cnt == 3'd4) begin
                            w_err       = 1'b1;
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                            w_buf_nxt   = '0;
                        end else if (w_tag == c_TAG_CONT) begin
                            w_buf_nxt = w_buf_ins;
                            w_cnt_nxt = r_cnt + 3'd1;
                        end else begin
                            w_push      = 1'b1;
                            w_word      = w_buf_ins;
                            w_len       = r_cnt + 3'd1;
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                            w_buf_nxt   = '0;
                        end
                    end
                    c_TAG_START: begin
                        w_err     = 1'b1;
                        w_buf_nxt = w_single;
                        w_cnt_nxt = 3'd1;
                    end
                    default: begin
                        w_err       = 1'b1;
                        w_push      = 1'b1;
                        w_word      = w_single;
                        w_len       = 3'd1;
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_buf_nxt   = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_buf   <= w_buf_nxt;
        end
    end

    // Two-entry output FIFO; a full FIFO still accepts a push when it pops.
    logic [31:0] r_mem_word [0:1];
    logic [2:0]  r_mem_len  [0:1];
    logic        r_rd_ptr, r_wr_ptr;
    logic [1:0]  r_fill;
    logic        w_pop, w_full, w_accept, w_drop;
    logic        r_seq_err, r_drop;

    assign w_pop    = out_valid && out_ready;
    assign w_full   = (r_fill == 2'd2);
    assign w_accept = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;

    assign out_valid = (r_fill != 2'd0);
    assign out_word  = out_valid ? r_mem_word[r_rd_ptr] : 32'd0;
    assign out_len   = out_valid ? r_mem_len[r_rd_ptr]  : 3'd0;
    assign seq_err   = r_seq_err;
    assign drop      = r_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_word[0] <= '0;
            r_mem_word[1] <= '0;
            r_mem_len[0]  <= '0;
            r_mem_len[1]  <= '0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_fill        <= '0;
            r_seq_err     <= 1'b0;
            r_drop        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem_word[r_wr_ptr] <= w_word;
                r_mem_len[r_wr_ptr]  <= w_len;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_fill <= r_fill + 2'd1;
                2'b01:   r_fill <= r_fill - 2'd1;
                default: r_fill <= r_fill;
            endcase
            r_seq_err <= w_err;
            r_drop    <= w_drop;
        end
    end

`ifdef NOP_META_STATS_EN
    logic [15:0] r_words_done;
    logic [7:0]  r_err_count;
    logic [8:0]  w_err_sum;

    assign w_err_sum = {1'b0, r_err_count} + {7'b0, w_err} + {7'b0, w_drop};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_words_done <= '0;
            r_err_count  <= '0;
        end else begin
            if (w_accept && (r_words_done != 16'hFFFF)) begin
                r_words_done <= r_words_done + 16'd1;
            end
            r_err_count <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];
        end
    end

    assign words_done = r_words_done;
    assign err_count  = r_err_count;
`else
    assign words_done = 16'd0;
    assign err_count  = 8'd0;
`endif

endmodule
`default_nettype wire
